// File: rtl/cpu_clk_pkg.sv
// Shared types and default dividers for the CPU clock-enable scheduler.
// Dividers are counted in 100 MHz fabric cycles.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_HALT,
    S_STEP,
    S_RUN
  } state_e;

  localparam int unsigned DEF_SLOW_DIV        = 200_000_000;
  localparam int unsigned DEF_FAST_DIV        = 1_000_000;
  localparam int unsigned DEF_REFRESH_DIV     = 20_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

  // SLOW and FAST share the RUN state; the divider is chosen separately.
  function automatic state_e mode_to_state(input mode_e m);
    case (m)
      MODE_HALT: mode_to_state = S_HALT;
      MODE_STEP: mode_to_state = S_STEP;
      default:   mode_to_state = S_RUN;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic btn_raw,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pulse_q, pulse_d;

  // Any cycle where the synced input agrees with the level restarts the count.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign rise_pulse = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable scheduler for the MIPS core: HALT / STEP / SLOW / FAST cpu_ce
// generation with hold deferral, plus a free-running display refresh strobe.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned SLOW_DIV        = DEF_SLOW_DIV,
  parameter int unsigned FAST_DIV        = DEF_FAST_DIV,
  parameter int unsigned REFRESH_DIV     = DEF_REFRESH_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic [1:0]  mode_sel,
  input  logic        step_btn,
  input  logic        hold,
  output logic        cpu_ce,
  output logic        refresh_tick,
  output logic [1:0]  mode_q,
  output logic        pending,
  output logic [15:0] ce_count
);

  localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int RW = $clog2(MAX_DIV) + 1;
  localparam int FW = $clog2(REFRESH_DIV) + 1;
  localparam logic [RW-1:0] SLOW_LAST = RW'(SLOW_DIV - 1);
  localparam logic [RW-1:0] FAST_LAST = RW'(FAST_DIV - 1);
  localparam logic [FW-1:0] REF_LAST  = FW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic [1:0]    mode_s1_q, mode_s1_d, mode_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [FW-1:0] refresh_q, refresh_d;
  logic          ce_q, ce_d;
  logic          pending_q, pending_d;
  logic [15:0]   ce_count_q, ce_count_d;

  logic          step_pulse;
  logic          mode_chg;
  logic          run_tick, step_tick, tick, blocked;
  logic [RW-1:0] div_last;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .btn_raw   (step_btn),
    .rise_pulse(step_pulse)
  );

  // State tracks the value mode_q is about to take, so state_q always decodes mode_q.
  always_ff @(posedge clk100MHz) begin
    if (rst) state_q <= S_HALT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = mode_to_state(mode_e'(mode_s1_q));
  end

  always_comb begin
    run_tick  = 1'b0;
    step_tick = 1'b0;
    case (state_q)
      S_STEP:  step_tick = step_pulse;
      S_RUN:   run_tick  = (rate_q == div_last);
      default: ;
    endcase
  end

  // mode_chg is the cycle in which mode_q updates; the rate count and any
  // deferred tick are discarded so the new mode starts from a clean slate.
  // A ce in the previous cycle also blocks issue, keeping cpu_ce single-cycle.
  always_comb begin
    mode_s1_d  = mode_sel;
    mode_d     = mode_s1_q;
    mode_chg   = (mode_s1_q != mode_q);
    div_last   = mode_q[0] ? FAST_LAST : SLOW_LAST;
    rate_d     = '0;
    if (!mode_chg && state_q == S_RUN && rate_q != div_last) begin
      rate_d = rate_q + RW'(1);
    end
    tick       = ~mode_chg & (run_tick | step_tick);
    blocked    = hold | ce_q;
    ce_d       = ~mode_chg & ~blocked & (tick | pending_q);
    pending_d  = ~mode_chg & blocked & (tick | pending_q);
    ce_count_d = ce_count_q + 16'(ce_d);
    refresh_d  = (refresh_q == REF_LAST) ? '0 : refresh_q + FW'(1);
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      mode_s1_q  <= 2'b00;
      mode_q     <= 2'b00;
      rate_q     <= '0;
      refresh_q  <= '0;
      ce_q       <= 1'b0;
      pending_q  <= 1'b0;
      ce_count_q <= '0;
    end else begin
      mode_s1_q  <= mode_s1_d;
      mode_q     <= mode_d;
      rate_q     <= rate_d;
      refresh_q  <= refresh_d;
      ce_q       <= ce_d;
      pending_q  <= pending_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce       = ce_q;
  assign pending      = pending_q;
  assign ce_count     = ce_count_q;
  assign refresh_tick = (refresh_q == REF_LAST);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl with small dividers
// (SLOW 8, FAST 4, REFRESH 5, DEBOUNCE 3).
module tb_cpu_clk_ctrl;

  localparam int unsigned SLOW_DIV        = 8;
  localparam int unsigned FAST_DIV        = 4;
  localparam int unsigned REFRESH_DIV     = 5;
  localparam int unsigned DEBOUNCE_CYCLES = 3;

  logic        clk100MHz = 1'b0;
  logic        rst;
  logic [1:0]  mode_sel;
  logic        step_btn;
  logic        hold;
  logic        cpu_ce;
  logic        refresh_tick;
  logic [1:0]  mode_q;
  logic        pending;
  logic [15:0] ce_count;

  int vectors    = 0;
  int miscompares = 0;

  cpu_clk_ctrl #(
    .SLOW_DIV       (SLOW_DIV),
    .FAST_DIV       (FAST_DIV),
    .REFRESH_DIV    (REFRESH_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .mode_sel    (mode_sel),
    .step_btn    (step_btn),
    .hold        (hold),
    .cpu_ce      (cpu_ce),
    .refresh_tick(refresh_tick),
    .mode_q      (mode_q),
    .pending     (pending),
    .ce_count    (ce_count)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic b, input logic h);
    rst      = r;
    mode_sel = m;
    step_btn = b;
    hold     = h;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk100MHz);
      #1;
    end
  endtask

  // Edges until cpu_ce is seen high; -1 if the budget expires.
  task automatic wait_ce(input int max_cycles, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk100MHz);
      #1;
      if (cpu_ce) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_ce(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(posedge clk100MHz);
      #1;
      if (cpu_ce) c++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int c;
    int first_ref;
    int n_ref;

    // Reset, then idle in HALT with a button press that must be ignored
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    step_cycles(2);
    checkOutput("reset_cpu_ce", cpu_ce, 0);
    checkOutput("reset_refresh", refresh_tick, 0);
    checkOutput("reset_mode_q", mode_q, 0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_ce_count", ce_count, 0);

    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    c = 0;
    first_ref = 0;
    n_ref = 0;
    for (int i = 1; i <= 25; i++) begin
      step_cycles(1);
      if (cpu_ce) c++;
      if (refresh_tick) begin
        n_ref++;
        if (first_ref == 0) first_ref = i;
      end
      if (i == 2)  step_btn = 1'b1;
      if (i == 14) step_btn = 1'b0;
    end
    checkOutput("halt_no_ce", c, 0);
    checkOutput("refresh_first", first_ref, 4);
    checkOutput("refresh_count", n_ref, 5);
    checkOutput("halt_ce_count", ce_count, 0);

    // FAST then SLOW run
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    step_cycles(1);
    checkOutput("fast_mode_q_1cyc", mode_q, 0);
    step_cycles(1);
    checkOutput("fast_mode_q_2cyc", mode_q, 3);
    wait_ce(20, n);
    checkOutput("fast_first_ce", n, 4);
    wait_ce(20, n);
    checkOutput("fast_period", n, 4);

    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
    step_cycles(1);
    checkOutput("ce_single_cycle", cpu_ce, 0);
    checkOutput("slow_mode_q_1cyc", mode_q, 3);
    step_cycles(1);
    checkOutput("slow_mode_q_2cyc", mode_q, 2);
    wait_ce(30, n);
    checkOutput("slow_first_ce", n, 8);
    wait_ce(30, n);
    checkOutput("slow_period", n, 8);
    checkOutput("run_ce_count", ce_count, 4);

    // STEP mode: glitches rejected, one clean press gives one ce
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    step_cycles(2);
    checkOutput("step_mode_q", mode_q, 1);
    c = 0;
    for (int g = 0; g < 2; g++) begin
      step_btn = 1'b1;
      count_ce(2, n);
      c += n;
      step_btn = 1'b0;
      count_ce(3, n);
      c += n;
    end
    count_ce(4, n);
    c += n;
    checkOutput("glitch_no_ce", c, 0);
    step_btn = 1'b1;
    wait_ce(20, n);
    checkOutput("step_latency", n, 6);
    count_ce(10, c);
    checkOutput("step_held_no_extra", c, 0);
    step_btn = 1'b0;
    count_ce(8, c);
    checkOutput("step_release_no_ce", c, 0);
    checkOutput("step_ce_count", ce_count, 5);

    // FAST with hold: ticks deferred and merged into one ce
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    step_cycles(2);
    checkOutput("hold_mode_q", mode_q, 3);
    hold = 1'b1;
    count_ce(20, c);
    checkOutput("hold_no_ce", c, 0);
    checkOutput("hold_pending", pending, 1);
    hold = 1'b0;
    step_cycles(1);
    checkOutput("release_ce", cpu_ce, 1);
    checkOutput("release_pending", pending, 0);
    checkOutput("release_ce_count", ce_count, 6);
    step_cycles(1);
    checkOutput("release_single_ce", cpu_ce, 0);

    // ce_count wrap from 0xFFFF
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    step_cycles(3);
    force dut.ce_count_q = 16'hFFFF;
    step_cycles(1);
    release dut.ce_count_q;
    checkOutput("preload_ce_count", ce_count, 16'hFFFF);
    step_cycles(1);
    checkOutput("preload_hold", ce_count, 16'hFFFF);
    applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
    wait_ce(20, n);
    checkOutput("wrap_ce_latency", n, 6);
    checkOutput("wrap_ce_count", ce_count, 0);

    // Reset while a SLOW tick is pending
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b1);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step_cycles(1);
      if (pending) begin
        n = i;
        break;
      end
    end
    checkOutput("slow_pending_at", n, 10);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    step_cycles(1);
    checkOutput("rst_cpu_ce", cpu_ce, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_ce_count", ce_count, 0);
    checkOutput("rst_mode_q", mode_q, 0);
    checkOutput("rst_refresh", refresh_tick, 0);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
    step_cycles(1);
    checkOutput("rerun_mode_q_1cyc", mode_q, 0);
    checkOutput("rerun_no_ce", cpu_ce, 0);
    step_cycles(1);
    checkOutput("rerun_mode_q_2cyc", mode_q, 2);
    wait_ce(30, n);
    checkOutput("rerun_first_ce", n, 8);
    checkOutput("rerun_ce_count", ce_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
